// File: rtl/oflow_pe_registration.sv
// Optical-flow PE registration: scans previous-frame candidates,
// picks the lowest L1 feature cost and assigns a matched or new ID.
module oflow_pe_registration #(
  parameter int FEATURE_NUM = 4,
  parameter int FEATURE_W   = 10,
  parameter int CAND_MAX    = 8,
  parameter int ID_LEN      = 12,
  parameter int COST_W      = FEATURE_W + 2
) (
  input  logic                             clk,
  input  logic                             reset_N,
  input  logic                             start_registration,
  input  logic [FEATURE_NUM*FEATURE_W-1:0] cur_features,
  input  logic [$clog2(CAND_MAX+1)-1:0]    num_of_candidates,
  input  logic [COST_W-1:0]                threshold,
  input  logic                             clear_ids,
  output logic                             cand_rd_en,
  output logic [$clog2(CAND_MAX)-1:0]      cand_addr,
  input  logic [FEATURE_NUM*FEATURE_W-1:0] cand_features,
  input  logic [ID_LEN-1:0]                cand_id,
  input  logic                             cand_valid,
  output logic                             done_registration,
  output logic [ID_LEN-1:0]                matched_id,
  output logic                             is_new_id,
  output logic [COST_W-1:0]                min_cost
);

  localparam int NW = $clog2(CAND_MAX+1);
  localparam int AW = $clog2(CAND_MAX);
  localparam int FW = FEATURE_NUM*FEATURE_W;
  localparam int RW = FEATURE_W + $clog2(FEATURE_NUM) + 1;
  localparam int SW = (RW > COST_W) ? RW : COST_W + 1;

  typedef enum logic [2:0] {
    IDLE, SCAN, DRAIN, DECIDE, DONE
  } state_t;

  state_t state_q, state_d;

  logic [FW-1:0]     cur_q;
  logic [NW-1:0]     n_q;
  logic [NW-1:0]     n_clip;
  logic              eval_q;
  logic [COST_W-1:0] best_cost_q;
  logic [ID_LEN-1:0] best_id_q;
  logic              best_valid_q;
  logic [ID_LEN-1:0] next_free_id;
  logic [COST_W-1:0] cost;
  logic              idle_like;
  logic              start_ok;
  logic              last_rd;
  logic              hit;

  assign n_clip = (num_of_candidates > NW'(CAND_MAX))
                ? NW'(CAND_MAX) : num_of_candidates;

  assign idle_like = (state_q == IDLE) || (state_q == DONE);
  assign start_ok  = start_registration && idle_like;
  assign last_rd   = (NW'(cand_addr) == n_q - NW'(1));
  assign hit       = best_valid_q && (best_cost_q <= threshold);

  // L1 distance between latched features and the returned candidate
  always_comb begin
    logic [SW-1:0]        sum;
    logic [FEATURE_W-1:0] a;
    logic [FEATURE_W-1:0] b;
    logic [FEATURE_W-1:0] diff;
    sum  = '0;
    a    = '0;
    b    = '0;
    diff = '0;
    for (int k = 0; k < FEATURE_NUM; k++) begin
      a    = cur_q[k*FEATURE_W +: FEATURE_W];
      b    = cand_features[k*FEATURE_W +: FEATURE_W];
      diff = (a > b) ? a - b : b - a;
      sum  = sum + SW'(diff);
    end
    cost = (sum > SW'({COST_W{1'b1}}))
         ? {COST_W{1'b1}} : sum[COST_W-1:0];
  end

  // state register
  always_ff @(posedge clk) begin
    if (!reset_N) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (start_registration)
          state_d = (n_clip == '0) ? DECIDE : SCAN;
      end
      SCAN:    if (last_rd) state_d = DRAIN;
      DRAIN:   state_d = DECIDE;
      DECIDE:  state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  // read sequencing, best tracking and result registers
  always_ff @(posedge clk) begin
    if (!reset_N) begin
      cur_q             <= '0;
      n_q               <= '0;
      eval_q            <= 1'b0;
      best_cost_q       <= '1;
      best_id_q         <= '0;
      best_valid_q      <= 1'b0;
      next_free_id      <= '0;
      cand_rd_en        <= 1'b0;
      cand_addr         <= '0;
      done_registration <= 1'b0;
      matched_id        <= '0;
      is_new_id         <= 1'b0;
      min_cost          <= '1;
    end else begin
      eval_q <= cand_rd_en;
      if (idle_like && clear_ids)
        next_free_id <= '0;
      if (start_ok) begin
        cur_q             <= cur_features;
        n_q               <= n_clip;
        best_cost_q       <= '1;
        best_valid_q      <= 1'b0;
        done_registration <= 1'b0;
        cand_rd_en        <= (n_clip != '0);
        cand_addr         <= '0;
      end else if (state_q == SCAN) begin
        if (last_rd) cand_rd_en <= 1'b0;
        else         cand_addr  <= cand_addr + AW'(1);
      end
      if (eval_q && cand_valid && (cost < best_cost_q)) begin
        best_cost_q  <= cost;
        best_id_q    <= cand_id;
        best_valid_q <= 1'b1;
      end
      if (state_q == DECIDE) begin
        done_registration <= 1'b1;
        min_cost          <= best_cost_q;
        if (hit) begin
          matched_id <= best_id_q;
          is_new_id  <= 1'b0;
        end else begin
          matched_id   <= next_free_id;
          is_new_id    <= 1'b1;
          next_free_id <= next_free_id + ID_LEN'(1);
        end
      end
    end
  end

endmodule
